// File: rtl/mem_cache_if.sv
// Pipeline (MEM stage) and backing-memory signals of the word cache.
interface mem_cache_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
) ();
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              cache_hit;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  re, we, addr, wr_data, mem_ready, mem_rdata,
    output rd_data, cache_hit, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output re, we, addr, wr_data, mem_ready, mem_rdata,
    input  rd_data, cache_hit, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_cache.sv
// Direct-mapped write-through, no-write-allocate word cache with
// saturating hit/miss counters.
module mem_cache #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_cache_if.slave  bus,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, WR_DONE} state_e;

  state_e                         state_q, state_d;
  logic [LINES-1:0]               valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [LINES-1:0][DATA_W-1:0]   data_q, data_d;
  logic                           mem_req_q, mem_req_d;
  logic                           mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]              mem_wdata_q, mem_wdata_d;
  logic                           refill_q, refill_d;
  logic [15:0]                    hit_cnt_q, hit_cnt_d;
  logic [15:0]                    miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag;
  logic             line_hit, stall;

  assign idx      = bus.addr[IDX_W-1:0];
  assign tag      = bus.addr[ADDR_W-1:IDX_W];
  assign fill_idx = mem_addr_q[IDX_W-1:0];
  assign line_hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    refill_d    = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.we) begin
          if (line_hit) data_d[idx] = bus.wr_data;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.addr;
          mem_wdata_d = bus.wr_data;
          stall       = 1'b1;
          state_d     = WR_THRU;
        end else if (bus.re) begin
          if (line_hit) begin
            // The first hit after a fill belongs to the miss already counted.
            if (!refill_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.addr;
            stall      = 1'b1;
            state_d    = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          valid_d[fill_idx] = 1'b1;
          tag_d[fill_idx]   = mem_addr_q[ADDR_W-1:IDX_W];
          data_d[fill_idx]  = bus.mem_rdata;
          mem_req_d         = 1'b0;
          refill_d          = 1'b1;
          state_d           = IDLE;
        end
      end
      WR_THRU: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = WR_DONE;
        end
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      refill_q    <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      refill_q    <= refill_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.cache_hit = bus.re & ~bus.we & line_hit;
  assign bus.stall     = stall;
  assign bus.rd_data   = (bus.cache_hit && !stall) ? data_q[idx] : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;
endmodule

// File: doc/mem_cache.md
# mem_cache

Direct-mapped, write-through, no-write-allocate word cache sitting between the pipeline's MEM stage and the backing main memory. It serves MEM-stage loads from a small register-based line array and reports `cache_hit`. It forwards every store to main memory and stalls the pipeline until misses and stores complete. It also keeps saturating hit/miss counters for performance debug.

## Interface
- `ADDR_W`, 22, word address width (matches MEM-stage `addr`)
- `DATA_W`, 32, data word width
- `IDX_W`, 3, index bits; 2^IDX_W lines of one word each; tag = `addr[ADDR_W-1:IDX_W]`
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `re`  in  1  MEM-stage read request
- `we`  in  1  MEM-stage write request; wins over `re` if both high
- `addr`  in  ADDR_W  word address
- `wr_data`  in  DATA_W  store data
- `rd_data`  out  DATA_W  load data; valid when `re & cache_hit & !stall`, else 0
- `cache_hit`  out  1  current read request hits a valid line (combinational)
- `stall`  out  1  pipeline must hold `re/we/addr/wr_data` stable
- `mem_req`  out  1  backing-memory request, held until `mem_ready`
- `mem_we`  out  1  request is a write
- `mem_addr`  out  ADDR_W  request address
- `mem_wdata`  out  DATA_W  request write data
- `mem_ready`  in  1  one-cycle completion pulse from main memory
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`
- `hit_cnt`  out  16  saturating count of read hits
- `miss_cnt`  out  16  saturating count of read misses

## Operation
- Storage per line: `valid`, tag, data. Lookup is combinational on `addr`.
- FSM states: IDLE, RD_MISS, WR_THRU, WR_DONE.
- **IDLE**, `we`=1:
  - If the tag matches a valid line, update that line's data with `wr_data`.
  - Latch `addr`/`wr_data` into the request registers.
  - Go to WR_THRU. `stall`=1 this cycle.
- **IDLE**, `re`=1, hit:
  - `rd_data`=line data, `cache_hit`=1, `stall`=0.
  - `hit_cnt`++. Stay in IDLE.
- **IDLE**, `re`=1, miss:
  - `stall`=1, `miss_cnt`++.
  - Latch `addr` into the request register. Go to RD_MISS.
- **RD_MISS**:
  - `mem_req`=1, `mem_we`=0, `stall`=1.
  - On `mem_ready`: write `mem_rdata`, tag, and `valid`=1 into the indexed line (evicting unconditionally). Go to IDLE.
  - The held `re` then hits in IDLE. `hit_cnt` is not incremented for this refill hit.
- **WR_THRU**:
  - `mem_req`=1, `mem_we`=1, `stall`=1.
  - On `mem_ready`, go to WR_DONE. A write miss never allocates.
- **WR_DONE**:
  - `stall`=0 for exactly one cycle. The pipeline advances and the held request is not re-issued.
  - Next state is IDLE.
- No request (`re`=`we`=0) in IDLE: `stall`=0, `cache_hit`=0, `rd_data`=0.
- `mem_ready` outside RD_MISS/WR_THRU is ignored.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset (`rst_n` low at a clock edge):
  - State goes to IDLE and all `valid` bits clear. Data and tag arrays need not reset.
  - `mem_req`, `mem_we`, `hit_cnt`, `miss_cnt` = 0. `mem_addr`, `mem_wdata` = 0.
  - `stall`, `cache_hit`, `rd_data` = 0 while `re`=`we`=0.
- Reset during RD_MISS/WR_THRU abandons the transaction: `mem_req` is low the cycle after the reset edge, and a late `mem_ready` is ignored.
- Read hit: 0 extra cycles (data in the request cycle).
- Read miss: `stall` high for L+1 cycles, where L = cycles from `mem_req` rising to `mem_ready`. Data is returned in the IDLE cycle after the fill.
- Write: `stall` high for L+1 cycles, then the WR_DONE cycle with `stall`=0.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered outputs, stable for the whole request.
- A `mem_ready` pulse in the same cycle as `mem_req` first rises is legal and completes the request (L=1 minimum at the cache boundary).

## Test plan
- Reset, then `re`=1 `addr`=0x000005 with memory returning 0xDEADBEEF at L=3:
  - `stall` high 4 cycles and `miss_cnt`=1.
  - Next cycle `cache_hit`=1, `rd_data`=0xDEADBEEF.
  - Repeated read: `hit_cnt`=1, no stall.
- Fill 0x000005, then read 0x00000D (same index 5, different tag):
  - Result is a miss and an eviction.
  - Re-reading 0x000005 misses again.
- Fill 0x000002, then write 0xCAFEF00D to 0x000002:
  - `mem_we`=1, `mem_addr`=0x000002, `stall` for L+1 cycles, then a WR_DONE cycle with `stall`=0.
  - A following read hits and returns 0xCAFEF00D.
- Write to uncached 0x000003, then read 0x000003:
  - The write completes via memory only.
  - The read misses (no-allocate).
- Assert `rst_n`=0 one cycle into an RD_MISS, then pulse `mem_ready`:
  - `mem_req`=0 the cycle after reset.
  - The late `mem_ready` is ignored, all lines are invalid, and counters are 0.
- Force `hit_cnt` to 0xFFFE, then do 3 read hits: `hit_cnt` holds at 0xFFFF.
